// File: rtl/alu_issue_stage_pkg.sv
// ============================================================================
// Module   : alu_defs (package)
// Purpose  : ALU opcode encoding, MIPS opcode/funct constants, issue entry type.
//            Optional macro: ALU_ISSUE_OVF_TRAP_EN adds the ovf_trap field.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_defs;

  localparam int ALU_DATA_WIDTH = 32;
  localparam int ALU_OP_WIDTH   = 4;

  localparam logic [ALU_OP_WIDTH-1:0] c_alu_and  = 4'b0000;
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_or   = 4'b0001;
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_add  = 4'b0010;
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_lui  = 4'b0011;
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_sltu = 4'b0100;
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_sll  = 4'b0101;
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_sub  = 4'b0110;
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_slt  = 4'b0111;
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_nor  = 4'b1001;
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_xor  = 4'b1010;
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_sra  = 4'b1011;
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_srl  = 4'b1100;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_addiu = 6'h09;
  localparam logic [5:0] c_op_slti  = 6'h0A;
  localparam logic [5:0] c_op_sltiu = 6'h0B;
  localparam logic [5:0] c_op_andi  = 6'h0C;
  localparam logic [5:0] c_op_ori   = 6'h0D;
  localparam logic [5:0] c_op_xori  = 6'h0E;
  localparam logic [5:0] c_op_lui   = 6'h0F;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  localparam logic [5:0] c_fn_sll   = 6'h00;
  localparam logic [5:0] c_fn_srl   = 6'h02;
  localparam logic [5:0] c_fn_sra   = 6'h03;
  localparam logic [5:0] c_fn_sllv  = 6'h04;
  localparam logic [5:0] c_fn_srlv  = 6'h06;
  localparam logic [5:0] c_fn_srav  = 6'h07;
  localparam logic [5:0] c_fn_add   = 6'h20;
  localparam logic [5:0] c_fn_addu  = 6'h21;
  localparam logic [5:0] c_fn_sub   = 6'h22;
  localparam logic [5:0] c_fn_subu  = 6'h23;
  localparam logic [5:0] c_fn_and   = 6'h24;
  localparam logic [5:0] c_fn_or    = 6'h25;
  localparam logic [5:0] c_fn_xor   = 6'h26;
  localparam logic [5:0] c_fn_nor   = 6'h27;
  localparam logic [5:0] c_fn_slt   = 6'h2A;
  localparam logic [5:0] c_fn_sltu  = 6'h2B;

  // One buffered ID/EX entry; the top's slots hold this as-is.
  typedef struct packed {
    logic [ALU_DATA_WIDTH-1:0] a;
    logic [ALU_DATA_WIDTH-1:0] b;
    logic [ALU_OP_WIDTH-1:0]   op;
    logic                      illegal;
`ifdef ALU_ISSUE_OVF_TRAP_EN
    logic                      ovf_trap;
`endif
  } issue_entry_t;

endpackage

`default_nettype wire

// File: rtl/alu_issue_decode.sv
// ============================================================================
// Module   : alu_issue_decode
// Purpose  : Combinational MIPS instr/rs/rt -> ALU operands, opcode, illegal.
//            Optional macro: ALU_ISSUE_OVF_TRAP_EN drives the ovf_trap field.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_decode
  import alu_defs::*;
(
  input  logic [ALU_DATA_WIDTH-1:0] instr,
  input  logic [ALU_DATA_WIDTH-1:0] rs_data,
  input  logic [ALU_DATA_WIDTH-1:0] rt_data,
  output issue_entry_t              dec
);

  logic [5:0]                w_opcode;
  logic [5:0]                w_funct;
  logic [4:0]                w_shamt;
  logic [15:0]               w_imm;
  logic [ALU_DATA_WIDTH-1:0] w_imm_sext;
  logic [ALU_DATA_WIDTH-1:0] w_imm_zext;
  logic                      w_unused_fields;

  assign w_opcode        = instr[31:26];
  assign w_funct         = instr[5:0];
  assign w_shamt         = instr[10:6];
  assign w_imm           = instr[15:0];
  assign w_imm_sext      = {{(ALU_DATA_WIDTH-16){w_imm[15]}}, w_imm};
  assign w_imm_zext      = {{(ALU_DATA_WIDTH-16){1'b0}}, w_imm};
  // Register specifiers are resolved upstream; only their values arrive here.
  assign w_unused_fields = ^instr[25:16];

  always_comb begin
    dec         = '0;
    dec.op      = c_alu_add;
    dec.illegal = 1'b1;
    case (w_opcode)
      c_op_rtype: begin
        dec.a       = rs_data;
        dec.b       = rt_data;
        dec.illegal = 1'b0;
        case (w_funct)
          c_fn_add, c_fn_addu: dec.op = c_alu_add;
          c_fn_sub, c_fn_subu: dec.op = c_alu_sub;
          c_fn_and:            dec.op = c_alu_and;
          c_fn_or:             dec.op = c_alu_or;
          c_fn_xor:            dec.op = c_alu_xor;
          c_fn_nor:            dec.op = c_alu_nor;
          c_fn_slt:            dec.op = c_alu_slt;
          c_fn_sltu:           dec.op = c_alu_sltu;
          c_fn_sllv:           dec.op = c_alu_sll;
          c_fn_srlv:           dec.op = c_alu_srl;
          c_fn_srav:           dec.op = c_alu_sra;
          // Immediate shifts: shift amount comes from the shamt field.
          c_fn_sll: begin
            dec.op = c_alu_sll;
            dec.a  = {{(ALU_DATA_WIDTH-5){1'b0}}, w_shamt};
          end
          c_fn_srl: begin
            dec.op = c_alu_srl;
            dec.a  = {{(ALU_DATA_WIDTH-5){1'b0}}, w_shamt};
          end
          c_fn_sra: begin
            dec.op = c_alu_sra;
            dec.a  = {{(ALU_DATA_WIDTH-5){1'b0}}, w_shamt};
          end
          default: begin
            dec.a       = '0;
            dec.b       = '0;
            dec.op      = c_alu_add;
            dec.illegal = 1'b1;
          end
        endcase
`ifdef ALU_ISSUE_OVF_TRAP_EN
        dec.ovf_trap = (w_funct == c_fn_add) || (w_funct == c_fn_sub);
`endif
      end
      c_op_addi, c_op_addiu, c_op_lw, c_op_sw: begin
        dec.a       = rs_data;
        dec.b       = w_imm_sext;
        dec.op      = c_alu_add;
        dec.illegal = 1'b0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
        dec.ovf_trap = (w_opcode == c_op_addi);
`endif
      end
      c_op_slti: begin
        dec.a       = rs_data;
        dec.b       = w_imm_sext;
        dec.op      = c_alu_slt;
        dec.illegal = 1'b0;
      end
      c_op_sltiu: begin
        dec.a       = rs_data;
        dec.b       = w_imm_sext;
        dec.op      = c_alu_sltu;
        dec.illegal = 1'b0;
      end
      c_op_andi: begin
        dec.a       = rs_data;
        dec.b       = w_imm_zext;
        dec.op      = c_alu_and;
        dec.illegal = 1'b0;
      end
      c_op_ori: begin
        dec.a       = rs_data;
        dec.b       = w_imm_zext;
        dec.op      = c_alu_or;
        dec.illegal = 1'b0;
      end
      c_op_xori: begin
        dec.a       = rs_data;
        dec.b       = w_imm_zext;
        dec.op      = c_alu_xor;
        dec.illegal = 1'b0;
      end
      c_op_lui: begin
        dec.a       = '0;
        dec.b       = w_imm_zext;
        dec.op      = c_alu_lui;
        dec.illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Decode/issue stage with 2-entry skid buffer feeding the ALU.
//            Optional macro: ALU_ISSUE_OVF_TRAP_EN adds the ovf_trap output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_stage
  import alu_defs::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic                  illegal,
  output logic [31:0]           issue_count
`ifdef ALU_ISSUE_OVF_TRAP_EN
  ,
  output logic                  ovf_trap
`endif
);

  issue_entry_t w_dec;
  issue_entry_t r_main;
  issue_entry_t r_skid;
  logic         r_main_valid;
  logic         r_skid_valid;
  logic [31:0]  r_issue_count;
  logic         w_accept;
  logic         w_drain;

  alu_issue_decode u_decode (
    .instr   (instr),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .dec     (w_dec)
  );

  assign w_accept = in_valid & in_ready;
  assign w_drain  = r_main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main        <= '0;
      r_skid        <= '0;
      r_main_valid  <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_issue_count <= '0;
    end else begin
      if (w_drain) begin
        r_issue_count <= r_issue_count + 32'd1;
      end
      // Main slot frees up this edge: refill from skid first to keep order.
      if (!r_main_valid || w_drain) begin
        if (r_skid_valid) begin
          r_main       <= r_skid;
          r_main_valid <= 1'b1;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_main       <= w_dec;
          r_main_valid <= 1'b1;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign in_ready    = ~r_skid_valid;
  assign out_valid   = r_main_valid;
  assign alu_a       = r_main.a;
  assign alu_b       = r_main.b;
  assign alu_op      = r_main.op;
  assign illegal     = r_main.illegal;
  assign issue_count = r_issue_count;
`ifdef ALU_ISSUE_OVF_TRAP_EN
  assign ovf_trap    = r_main.ovf_trap;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Directed self-checking bench for alu_issue_stage.
//            Optional macro: ALU_ISSUE_OVF_TRAP_EN enables trap-flag vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic        illegal;
  logic [31:0] issue_count;
`ifdef ALU_ISSUE_OVF_TRAP_EN
  logic        ovf_trap;
`endif

  int n_tests;
  int n_fail;

  alu_issue_stage #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .illegal     (illegal),
    .issue_count (issue_count)
`ifdef ALU_ISSUE_OVF_TRAP_EN
    ,
    .ovf_trap    (ovf_trap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, 5'd1, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [15:0] imm);
    return {op, rs, 5'd2, imm};
  endfunction

  // Presents one instruction for a single cycle; returns #1 after the edge.
  task automatic issue(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    instr    = i;
    rs_data  = rs;
    rt_data  = rt;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic ill);
    check_val({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check_val({tag, ".a"}, alu_a, a);
    check_val({tag, ".b"}, alu_b, b);
    check_val({tag, ".op"}, {28'd0, alu_op}, {28'd0, op});
    check_val({tag, ".ill"}, {31'd0, illegal}, {31'd0, ill});
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    instr     = '0;
    rs_data   = '0;
    rt_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst.alu_a", alu_a, 32'd0);
    check_val("rst.alu_op", {28'd0, alu_op}, 32'd0);
    check_val("rst.count", issue_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(itype(6'h08, 5'd1, 16'hFFFF), 32'h7FFF_FFFF, 32'h0);
    check_out("addi", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'b0010, 1'b0);
    check_val("addi.count", issue_count, 32'd0);

    issue(rtype(5'd0, 5'd3, 5'd4, 6'h00), 32'hDEAD_BEEF, 32'h3);
    check_out("sll", 32'h4, 32'h3, 4'b0101, 1'b0);
    check_val("sll.count", issue_count, 32'd1);

    issue(rtype(5'd1, 5'd3, 5'd9, 6'h07), 32'h21, 32'h8000_0000);
    check_out("srav", 32'h21, 32'h8000_0000, 4'b1011, 1'b0);

    issue(itype(6'h0F, 5'd0, 16'h1234), 32'h5555_5555, 32'h0);
    check_out("lui", 32'h0, 32'h1234, 4'b0011, 1'b0);

    issue(itype(6'h0D, 5'd1, 16'h8000), 32'hFFFF_0000, 32'h0);
    check_out("ori", 32'hFFFF_0000, 32'h8000, 4'b0001, 1'b0);

    issue(itype(6'h0A, 5'd1, 16'h8000), 32'h10, 32'h0);
    check_out("slti", 32'h10, 32'hFFFF_8000, 4'b0111, 1'b0);

    issue(rtype(5'd1, 5'd2, 5'd0, 6'h27), 32'hF0F0_0000, 32'h0F0F);
    check_out("nor", 32'hF0F0_0000, 32'h0F0F, 4'b1001, 1'b0);

    issue({6'h3F, 26'h3FF_FFFF}, 32'h5, 32'h6);
    check_out("illop", 32'h0, 32'h0, 4'b0010, 1'b1);

    issue(rtype(5'd1, 5'd2, 5'd0, 6'h01), 32'h5, 32'h6);
    check_out("illfn", 32'h0, 32'h0, 4'b0010, 1'b1);

    @(posedge clk);
    #1;
    check_val("drain.out_valid", {31'd0, out_valid}, 32'd0);
    check_val("drain.count", issue_count, 32'd9);

    // Back-pressure: three back-to-back offers with the consumer stalled.
    @(negedge clk);
    out_ready = 1'b0;
    instr     = rtype(5'd1, 5'd2, 5'd0, 6'h20);
    rs_data   = 32'h1;
    rt_data   = 32'h2;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    check_val("bp1.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    instr   = rtype(5'd1, 5'd2, 5'd0, 6'h26);
    rs_data = 32'h3;
    rt_data = 32'h5;
    @(posedge clk);
    #1;
    check_val("bp2.in_ready", {31'd0, in_ready}, 32'd0);
    check_out("bp2", 32'h1, 32'h2, 4'b0010, 1'b0);
    @(negedge clk);
    instr   = rtype(5'd0, 5'd2, 5'd7, 6'h02);
    rs_data = 32'h99;
    rt_data = 32'h100;
    @(posedge clk);
    #1;
    check_val("bp3.in_ready", {31'd0, in_ready}, 32'd0);
    check_out("bp3.hold", 32'h1, 32'h2, 4'b0010, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_out("bp.B", 32'h3, 32'h5, 4'b1010, 1'b0);
    check_val("bpB.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_out("bp.C", 32'h7, 32'h100, 4'b1100, 1'b0);
    @(posedge clk);
    #1;
    check_val("bp.end_valid", {31'd0, out_valid}, 32'd0);
    check_val("bp.count", issue_count, 32'd12);

    // Reset with both slots full and handshakes pending in the same cycle.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = itype(6'h0C, 5'd1, 16'h00FF);
    rs_data   = 32'h1234;
    repeat (2) @(posedge clk);
    #1;
    check_val("full.in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst2.out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst2.in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst2.count", issue_count, 32'd0);
    check_val("rst2.alu_a", alu_a, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;

`ifdef ALU_ISSUE_OVF_TRAP_EN
    issue(rtype(5'd1, 5'd2, 5'd0, 6'h22), 32'h9, 32'h4);
    check_out("sub", 32'h9, 32'h4, 4'b0110, 1'b0);
    check_val("sub.trap", {31'd0, ovf_trap}, 32'd1);
    issue(rtype(5'd1, 5'd2, 5'd0, 6'h23), 32'h9, 32'h4);
    check_val("subu.trap", {31'd0, ovf_trap}, 32'd0);
    issue(itype(6'h08, 5'd1, 16'h0001), 32'h9, 32'h0);
    check_val("addi.trap", {31'd0, ovf_trap}, 32'd1);
    issue(itype(6'h09, 5'd1, 16'h0001), 32'h9, 32'h0);
    check_val("addiu.trap", {31'd0, ovf_trap}, 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
